// File: rtl/pisca_pkg.sv
// Shared types and state-selection helpers for the multi-channel blinker.
package pisca_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BURST = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   // State entered on a restart (config write or sync).
   function automatic state_t start_state(mode_t mode, logic on_nz, logic burst_nz);
      if (mode == MODE_BLINK || (mode == MODE_BURST && burst_nz)) begin
         return on_nz ? ST_HIGH : ST_LOW;
      end
      return ST_IDLE;
   endfunction

   // State entered when a full high/low cycle has completed.
   function automatic state_t cycle_state(logic burst_done, logic on_nz);
      if (burst_done) begin
         return ST_IDLE;
      end
      return on_nz ? ST_HIGH : ST_LOW;
   endfunction

endpackage

// File: rtl/pisca_channel.sv
// One blink channel: config registers, phase FSM, phase and burst counters.
module pisca_channel
   import pisca_pkg::*;
#(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               restart,
   input  logic               load,
   input  mode_t              cfg_mode,
   input  logic [CNT_W-1:0]   cfg_on,
   input  logic [CNT_W-1:0]   cfg_off,
   input  logic [BURST_W-1:0] cfg_burst,
   output logic               pisca,
   output logic               busy
);

   mode_t              mode_q, mode_d;
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   on_q, on_d, off_q, off_d, cnt_q, cnt_d;
   logic [BURST_W-1:0] burst_q, burst_d, bcnt_q, bcnt_d;
   logic [CNT_W:0]     cnt_inc;
   logic [BURST_W:0]   bcnt_inc, bcnt_nxt;
   logic               is_burst, pisca_d, busy_d;

   assign is_burst = (mode_q == MODE_BURST);

   // Next-state: restart has priority over tick; lengths compared with >= so
   // counters never exceed the programmed length.
   always_comb begin
      mode_d   = mode_q;
      on_d     = on_q;
      off_d    = off_q;
      burst_d  = burst_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      bcnt_d   = bcnt_q;
      cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
      bcnt_inc = {1'b0, bcnt_q} + (BURST_W+1)'(1);
      bcnt_nxt = {1'b0, bcnt_q};
      if (restart) begin
         if (load) begin
            mode_d  = cfg_mode;
            on_d    = cfg_on;
            off_d   = cfg_off;
            burst_d = cfg_burst;
         end
         cnt_d   = '0;
         bcnt_d  = '0;
         state_d = start_state(mode_d, on_d != '0, burst_d != '0);
      end else if (tick) begin
         unique case (state_q)
            ST_HIGH: begin
               if (cnt_inc >= {1'b0, on_q}) begin
                  cnt_d    = '0;
                  bcnt_nxt = is_burst ? bcnt_inc : {1'b0, bcnt_q};
                  bcnt_d   = bcnt_nxt[BURST_W-1:0];
                  // Zero-length low phase: close the cycle right here.
                  if (off_q != '0) begin
                     state_d = ST_LOW;
                  end else begin
                     state_d = cycle_state(is_burst && bcnt_nxt >= {1'b0, burst_q},
                                           on_q != '0);
                  end
               end else begin
                  cnt_d = cnt_inc[CNT_W-1:0];
               end
            end
            ST_LOW: begin
               if (cnt_inc >= {1'b0, off_q}) begin
                  cnt_d    = '0;
                  // With on=0 each low phase counts as one burst blink.
                  bcnt_nxt = (is_burst && on_q == '0) ? bcnt_inc : {1'b0, bcnt_q};
                  bcnt_d   = bcnt_nxt[BURST_W-1:0];
                  state_d  = cycle_state(is_burst && bcnt_nxt >= {1'b0, burst_q},
                                         on_q != '0);
               end else begin
                  cnt_d = cnt_inc[CNT_W-1:0];
               end
            end
            default: ;
         endcase
      end
      pisca_d = (state_d == ST_HIGH) || (mode_d == MODE_ON);
      busy_d  = (mode_d == MODE_BURST) && (state_d != ST_IDLE);
   end

   // State and registered outputs, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q  <= MODE_OFF;
         state_q <= ST_IDLE;
         on_q    <= '0;
         off_q   <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         pisca   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         state_q <= state_d;
         on_q    <= on_d;
         off_q   <= off_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         pisca   <= pisca_d;
         busy    <= busy_d;
      end
   end

endmodule

// File: rtl/pisca_multi.sv
// N_CH independent blinkers sharing one prescaler and a global sync.
module pisca_multi
   import pisca_pkg::*;
#(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned BURST_W  = 8,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  cfg_we,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
   input  logic [1:0]                            cfg_mode,
   input  logic [CNT_W-1:0]                      cfg_on,
   input  logic [CNT_W-1:0]                      cfg_off,
   input  logic [BURST_W-1:0]                    cfg_burst,
   input  logic                                  sync,
   output logic [N_CH-1:0]                       pisca,
   output logic [N_CH-1:0]                       busy
);

   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRE_W-1:0] pre_q;
   logic             tick;

   assign tick = (pre_q == PRE_W'(PRESCALE - 1));

   // Prescaler: wraps on tick, restarted by sync so phases align exactly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q <= '0;
      end else if (sync || tick) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PRE_W'(1);
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic we_ch;
      // Out-of-range channel numbers match no instance and are dropped.
      assign we_ch = cfg_we && (cfg_ch == CH_W'(i));

      pisca_channel #(
         .CNT_W   (CNT_W),
         .BURST_W (BURST_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .tick      (tick),
         .restart   (we_ch || sync),
         .load      (we_ch),
         .cfg_mode  (mode_t'(cfg_mode)),
         .cfg_on    (cfg_on),
         .cfg_off   (cfg_off),
         .cfg_burst (cfg_burst),
         .pisca     (pisca[i]),
         .busy      (busy[i])
      );
   end

endmodule

// File: tb/tb_pisca_multi.sv
// Directed self-checking bench: dut_a (4 ch, PRESCALE=1), dut_b (3 ch, PRESCALE=4).
module tb_pisca_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [1:0]  cfg_mode = '0;
   logic [15:0] cfg_on = '0;
   logic [15:0] cfg_off = '0;
   logic [7:0]  cfg_burst = '0;
   logic        we_a = 1'b0, we_b = 1'b0, sync_a = 1'b0, sync_b = 1'b0;
   logic [3:0]  pisca_a, busy_a;
   logic [2:0]  pisca_b, busy_b;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   pisca_multi #(.N_CH(4), .CNT_W(16), .BURST_W(8), .PRESCALE(1)) dut_a (
      .clk(clk), .rst(rst), .cfg_we(we_a), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_burst(cfg_burst), .sync(sync_a),
      .pisca(pisca_a), .busy(busy_a)
   );

   pisca_multi #(.N_CH(3), .CNT_W(16), .BURST_W(8), .PRESCALE(4)) dut_b (
      .clk(clk), .rst(rst), .cfg_we(we_b), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_burst(cfg_burst), .sync(sync_b),
      .pisca(pisca_b), .busy(busy_b)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input bit to_b, input int ch, input int mode, input int on,
                     input int off, input int burst);
      cfg_ch    = 2'(ch);
      cfg_mode  = 2'(mode);
      cfg_on    = 16'(on);
      cfg_off   = 16'(off);
      cfg_burst = 8'(burst);
      if (to_b) we_b = 1'b1;
      else      we_a = 1'b1;
      cyc();
      we_a = 1'b0;
      we_b = 1'b0;
   endtask

   initial begin
      // Reset hold with random write traffic.
      for (int i = 0; i < 3; i++) begin
         we_a      = 1'($urandom_range(0, 1));
         we_b      = 1'($urandom_range(0, 1));
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_mode  = 2'($urandom_range(1, 3));
         cfg_on    = 16'($urandom_range(1, 5));
         cfg_off   = 16'($urandom_range(1, 5));
         cfg_burst = 8'($urandom_range(1, 5));
         cyc();
         check_eq($sformatf("rst_pisca_a[%0d]", i), 32'(pisca_a), 32'h0);
         check_eq($sformatf("rst_busy_a[%0d]", i), 32'(busy_a), 32'h0);
         check_eq($sformatf("rst_pisca_b[%0d]", i), 32'(pisca_b), 32'h0);
         check_eq($sformatf("rst_busy_b[%0d]", i), 32'(busy_b), 32'h0);
      end
      we_a = 1'b0;
      we_b = 1'b0;
      rst  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check_eq($sformatf("idle_pisca_a[%0d]", i), 32'(pisca_a), 32'h0);
         check_eq($sformatf("idle_busy_a[%0d]", i), 32'(busy_a), 32'h0);
      end

      // BLINK ch0 on=3 off=2: 11100 repeating.
      wr(1'b0, 0, 2, 3, 2, 0);
      for (int k = 0; k < 20; k++) begin
         check_eq($sformatf("blink[%0d]", k), 32'(pisca_a[0]), 32'((k % 5) < 3));
         cyc();
      end

      // BURST ch1 on=2 off=1 burst=3: 110110110 then 0, busy for 9 cycles.
      wr(1'b0, 1, 3, 2, 1, 3);
      for (int k = 0; k < 13; k++) begin
         check_eq($sformatf("burst_pisca[%0d]", k), 32'(pisca_a[1]),
                  32'(k < 9 && (k % 3) != 2));
         check_eq($sformatf("burst_busy[%0d]", k), 32'(busy_a[1]), 32'(k < 9));
         cyc();
      end

      // Sync alignment of ch0 and ch2 written 3 cycles apart.
      wr(1'b0, 0, 2, 2, 2, 0);
      cyc();
      cyc();
      wr(1'b0, 2, 2, 2, 2, 0);
      sync_a = 1'b1;
      cyc();
      sync_a = 1'b0;
      for (int k = 0; k < 12; k++) begin
         check_eq($sformatf("sync_ch0[%0d]", k), 32'(pisca_a[0]), 32'((k % 4) < 2));
         check_eq($sformatf("sync_ch2[%0d]", k), 32'(pisca_a[2]), 32'((k % 4) < 2));
         cyc();
      end

      // BURST with burst=0 stays idle.
      wr(1'b0, 3, 3, 5, 5, 0);
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("b0_pisca[%0d]", k), 32'(pisca_a[3]), 32'h0);
         check_eq($sformatf("b0_busy[%0d]", k), 32'(busy_a[3]), 32'h0);
         cyc();
      end

      // BLINK off=0 holds high; on=0 holds low.
      wr(1'b0, 0, 2, 4, 0, 0);
      wr(1'b0, 2, 2, 0, 3, 0);
      for (int k = 0; k < 10; k++) begin
         check_eq($sformatf("off0_pisca[%0d]", k), 32'(pisca_a[0]), 32'h1);
         check_eq($sformatf("on0_pisca[%0d]", k), 32'(pisca_a[2]), 32'h0);
         cyc();
      end

      // BURST off=0: two back-to-back high phases of 2 ticks.
      wr(1'b0, 3, 3, 2, 0, 2);
      for (int k = 0; k < 7; k++) begin
         check_eq($sformatf("boff0_pisca[%0d]", k), 32'(pisca_a[3]), 32'(k < 4));
         check_eq($sformatf("boff0_busy[%0d]", k), 32'(busy_a[3]), 32'(k < 4));
         cyc();
      end

      // BURST on=0: two low phases of 2 ticks, output stays low.
      wr(1'b0, 3, 3, 0, 2, 2);
      for (int k = 0; k < 7; k++) begin
         check_eq($sformatf("bon0_pisca[%0d]", k), 32'(pisca_a[3]), 32'h0);
         check_eq($sformatf("bon0_busy[%0d]", k), 32'(busy_a[3]), 32'(k < 4));
         cyc();
      end

      // Out-of-range channel on the 3-channel instance.
      wr(1'b1, 0, 1, 0, 0, 0);
      check_eq("ch_on_b", 32'(pisca_b), 32'h1);
      wr(1'b1, 3, 0, 0, 0, 0);
      check_eq("ch_oob_pisca_b", 32'(pisca_b), 32'h1);
      check_eq("ch_oob_busy_b", 32'(busy_b), 32'h0);
      wr(1'b1, 3, 1, 0, 0, 0);
      check_eq("ch_oob_on_b", 32'(pisca_b), 32'h1);

      // Asynchronous reset in the middle of a burst.
      wr(1'b0, 1, 3, 2, 1, 3);
      cyc();
      check_eq("mid_pisca", 32'(pisca_a[1]), 32'h1);
      check_eq("mid_busy", 32'(busy_a[1]), 32'h1);
      #3;
      rst = 1'b0;
      #1;
      check_eq("async_pisca_a", 32'(pisca_a), 32'h0);
      check_eq("async_busy_a", 32'(busy_a), 32'h0);
      check_eq("async_pisca_b", 32'(pisca_b), 32'h0);
      cyc();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         check_eq($sformatf("post_rst_pisca[%0d]", k), 32'(pisca_a), 32'h0);
         check_eq($sformatf("post_rst_busy[%0d]", k), 32'(busy_a), 32'h0);
      end

      // PRESCALE=4, sync after on=1 off=1: 4 high, 4 low.
      wr(1'b1, 0, 2, 1, 1, 0);
      sync_b = 1'b1;
      cyc();
      sync_b = 1'b0;
      for (int k = 0; k < 24; k++) begin
         check_eq($sformatf("pre4[%0d]", k), 32'(pisca_b[0]), 32'((k % 8) < 4));
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pisca_multi.md
Name: pisca_multi

Overview:
Parametrised multi-channel successor to pisca_pisca. It drives N_CH independent blink outputs. Each channel has its own runtime-programmable high/low lengths and mode: off, on, continuous blink, or a finite burst of blinks. A shared prescaler sets the time base, and a global sync input phase-aligns all channels. The block sits between a control/register interface and the LED/indicator pins.

Parameters:
N_CH, 4, number of independent output channels (>=1)
CNT_W, 16, width of the high/low phase-length counters, in ticks
BURST_W, 8, width of the burst blink count
PRESCALE, 1, clock cycles per tick (>=1); PRESCALE=1 means one tick per clock

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low; all state cleared while rst=0
cfg_we  input  1  config write strobe, single-cycle
cfg_ch  input  $clog2(N_CH) (min 1)  target channel of the write
cfg_mode  input  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 BURST
cfg_on  input  CNT_W  high-phase length in ticks
cfg_off  input  CNT_W  low-phase length in ticks
cfg_burst  input  BURST_W  number of high phases in BURST mode
sync  input  1  global restart of all channels and the prescaler
pisca  output  N_CH  registered blink outputs, one bit per channel
busy  output  N_CH  high while a channel's burst is in progress

Behaviour:
- Reset (rst=0, async): pisca=0, busy=0, all modes OFF, on/off/burst registers 0, prescaler 0, all channel FSMs IDLE.
- Prescaler: counts 0..PRESCALE-1 and asserts tick when it reaches PRESCALE-1, then wraps. sync clears it to 0. cfg_we does not affect it.
- Channel FSM states: IDLE, HIGH, LOW. pisca=1 only in HIGH, or in mode ON.
- Config write: on the clk edge with cfg_we=1, the addressed channel latches mode/on/off/burst, clears its phase counter and burst count, and restarts.
  - If cfg_ch>=N_CH, the write is ignored.
  - The new output is visible on the cycle after the write edge (1-cycle latency).
- Restart target:
  - OFF: go to IDLE, pisca=0.
  - ON: go to IDLE, pisca=1.
  - BLINK, or BURST with burst!=0: go to HIGH if on!=0, otherwise LOW.
  - BURST with burst=0: go to IDLE, pisca=0, busy=0.
- HIGH: the phase counter increments on each tick. After on ticks, go to LOW and clear the counter. BURST increments the burst count on this exit.
- LOW: after off ticks, BLINK returns to HIGH. BURST returns to HIGH if burst count<burst, otherwise goes to IDLE (pisca=0, busy falls).
- Phase lengths are exact at PRESCALE=1. With PRESCALE>1, the first phase after a cfg_we may be shortened by up to PRESCALE-1 cycles. After sync, all phases are exact.
- Degenerate lengths (BLINK/BURST):
  - on=0: never enters HIGH; pisca stays 0. BURST completes after burst LOW phases.
  - off=0 with on!=0 in BLINK: HIGH is immediately re-entered, so pisca stays 1.
  - off=0 in BURST: HIGH phases run back to back with no gap.
- busy: 1 from the BURST restart until the final LOW phase completes. Always 0 in the other modes.
- sync: every channel in BLINK/BURST restarts as on a config write, using its current config. The prescaler restarts too.
- Simultaneous sync and cfg_we: the write channel restarts with the new config; all other channels restart with their old config.
- Reset mid-burst: immediately pisca=0, busy=0, mode OFF. The channel stays idle until rewritten.
- Counters compare with >= against the programmed length, so a mid-phase rewrite to a smaller value cannot overrun via wrap-around. No arithmetic overflow is possible, because each counter never exceeds its programmed length.

Decomposition:
- Package pisca_pkg holds:
  - mode_t enum {MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST}
  - state_t enum {ST_IDLE, ST_HIGH, ST_LOW}
- Sub-module pisca_channel contains one channel's config registers, FSM, phase counter and burst counter. Its inputs are tick, restart and the config fields; its outputs are pisca and busy.
- Top pisca_multi holds the prescaler, decodes cfg_ch to per-channel write enables, and generates N_CH instances of pisca_channel.

Test Plan:
1. Reset hold: rst=0 for 3 cycles with random cfg_we -> pisca=0 and busy=0 throughout. After release with no writes, outputs stay 0.
2. BLINK, PRESCALE=1: ch0 on=3 off=2 -> starting 1 cycle after the write, pisca[0] repeats 1,1,1,0,0 with period 5 for at least 4 periods.
3. BURST: ch1 on=2 off=1 burst=3 -> pisca[1] = 110110110 then constant 0. busy[1]=1 for exactly 9 cycles, then 0.
4. Sync alignment: ch0 BLINK on=2/off=2 and ch2 BLINK on=2/off=2, written 3 cycles apart, then sync pulse -> pisca[0]==pisca[2] on every cycle after sync.
5. Edge cases:
   - ch3 BURST burst=0 -> pisca[3]=0, busy[3]=0.
   - BLINK off=0 -> pisca constant 1.
   - on=0 -> pisca constant 0.
   - cfg_ch=N_CH -> no channel changes.
6. Mid-operation and PRESCALE=4:
   - rst asserted mid-burst -> pisca and busy drop asynchronously, before the next clk edge.
   - PRESCALE=4 with sync then on=1 off=1 -> pisca toggles every 4 cycles.
